// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Opcode map and sequencer state encoding shared by the accumulator
//           CPU datapath, its control unit and the bench.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_JMPZ = 8'h06;
  localparam logic [7:0] OP_JPNZ = 8'h07;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_INAC = 8'h0A;
  localparam logic [7:0] OP_CLAC = 8'h0B;
  localparam logic [7:0] OP_AND  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_XOR  = 8'h0E;
  localparam logic [7:0] OP_NOT  = 8'h0F;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    EXEC_G  = 3'd4,
    HALT    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : instr_decoder
// Brief   : Combinational opcode classifier for the accumulator ISA.
// Revision: 1.0 - initial release
// ============================================================================
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int             OPW     = 8,
  parameter logic [OPW-1:0] HALT_OP = 8'hFF
) (
  input  logic [OPW-1:0] opcode_i,
  output logic           is_gamma_o,
  output logic           is_alu_o,
  output logic           is_branch_o,
  output logic           is_halt_o,
  output logic           is_legal_o
);

  always_comb begin
    is_branch_o = (opcode_i == OPW'(OP_JUMP)) || (opcode_i == OPW'(OP_JMPZ)) ||
                  (opcode_i == OPW'(OP_JPNZ));
    is_gamma_o  = is_branch_o || (opcode_i == OPW'(OP_LDAC)) || (opcode_i == OPW'(OP_STAC));
    is_alu_o    = (opcode_i >= OPW'(OP_ADD)) && (opcode_i <= OPW'(OP_NOT));
    is_halt_o   = (opcode_i == HALT_OP);
    is_legal_o  = (opcode_i <= OPW'(OP_NOT)) || is_halt_o;
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module  : control_unit
// Brief   : Fetch / address-fetch / execute sequencer driving every enable and
//           mux select of the 8-bit accumulator datapath.
// Revision: 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_pkg::*;
#(
  parameter int             OPW     = 8,
  parameter logic [OPW-1:0] HALT_OP = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           ACisZero,
  output logic           writeEnableAC,
  output logic           writeEnableR,
  output logic           writeEnableMem,
  output logic           PCEnable,
  output logic           instructionRegisterEnable,
  output logic           MSBaddressEnable,
  output logic           LSBaddressEnable,
  output logic           zeroEnable,
  output logic           muxOpcode,
  output logic           muxSelectPC,
  output logic           muxSelectAddress,
  output logic           muxSelectALUtoAC,
  output logic           muxSelectMEM_or_R_toAC,
  output logic           halted,
  output logic [2:0]     state_dbg
);

  state_t state_q, state_d;
  logic   w_is_gamma, w_is_alu, w_is_branch, w_is_halt, w_is_legal, w_taken;

  instr_decoder #(
    .OPW     (OPW),
    .HALT_OP (HALT_OP)
  ) u_decoder (
    .opcode_i    (opcode),
    .is_gamma_o  (w_is_gamma),
    .is_alu_o    (w_is_alu),
    .is_branch_o (w_is_branch),
    .is_halt_o   (w_is_halt),
    .is_legal_o  (w_is_legal)
  );

  assign w_taken = (opcode == OPW'(OP_JUMP)) ||
                   ((opcode == OPW'(OP_JMPZ)) && ACisZero) ||
                   ((opcode == OPW'(OP_JPNZ)) && !ACisZero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state_dbg = state_q;

  always_comb begin
    state_d                   = state_q;
    writeEnableAC             = 1'b0;
    writeEnableR              = 1'b0;
    writeEnableMem            = 1'b0;
    PCEnable                  = 1'b0;
    instructionRegisterEnable = 1'b0;
    MSBaddressEnable          = 1'b0;
    LSBaddressEnable          = 1'b0;
    zeroEnable                = 1'b0;
    muxOpcode                 = 1'b0;
    muxSelectPC               = 1'b0;
    muxSelectAddress          = 1'b0;
    muxSelectALUtoAC          = 1'b0;
    muxSelectMEM_or_R_toAC    = 1'b0;
    halted                    = 1'b0;

    case (state_q)
      FETCH: begin
        muxOpcode                 = 1'b1;
        instructionRegisterEnable = 1'b1;
        PCEnable                  = 1'b1;
        state_d                   = DECODE;
      end
      DECODE: begin
        state_d = FETCH;
        // Anything outside the map falls through here and executes as a NOP.
        if (w_is_legal) begin
          if (w_is_halt) begin
            state_d = HALT;
          end else if (w_is_gamma) begin
            state_d = ADDR_HI;
          end else if (w_is_alu) begin
            writeEnableAC = 1'b1;
            zeroEnable    = 1'b1;
          end else if (opcode == OPW'(OP_MOVR)) begin
            writeEnableAC    = 1'b1;
            zeroEnable       = 1'b1;
            muxSelectALUtoAC = 1'b1;
          end else if (opcode == OPW'(OP_MVAC)) begin
            writeEnableR = 1'b1;
          end
        end
      end
      ADDR_HI: begin
        MSBaddressEnable = 1'b1;
        PCEnable         = 1'b1;
        state_d          = ADDR_LO;
      end
      ADDR_LO: begin
        LSBaddressEnable = 1'b1;
        PCEnable         = 1'b1;
        state_d          = EXEC_G;
      end
      EXEC_G: begin
        state_d = FETCH;
        if (w_is_branch) begin
          muxSelectPC = w_taken;
          PCEnable    = w_taken;
        end else if (opcode == OPW'(OP_LDAC)) begin
          muxSelectAddress       = 1'b1;
          muxSelectALUtoAC       = 1'b1;
          muxSelectMEM_or_R_toAC = 1'b1;
          writeEnableAC          = 1'b1;
          zeroEnable             = 1'b1;
        end else if (opcode == OPW'(OP_STAC)) begin
          muxSelectAddress = 1'b1;
          writeEnableMem   = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset is asynchronous, so the FETCH outputs must not leak while it is held.
    if (!reset) begin
      writeEnableAC             = 1'b0;
      writeEnableR              = 1'b0;
      writeEnableMem            = 1'b0;
      PCEnable                  = 1'b0;
      instructionRegisterEnable = 1'b0;
      MSBaddressEnable          = 1'b0;
      LSBaddressEnable          = 1'b0;
      zeroEnable                = 1'b0;
      muxOpcode                 = 1'b0;
      muxSelectPC               = 1'b0;
      muxSelectAddress          = 1'b0;
      muxSelectALUtoAC          = 1'b0;
      muxSelectMEM_or_R_toAC    = 1'b0;
      halted                    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_unit
// Brief   : Control unit paired with a small accumulator datapath and memory,
//           compared instruction by instruction against an ISA-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic        ACisZero;
  logic        writeEnableAC, writeEnableR, writeEnableMem, PCEnable;
  logic        instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable, zeroEnable;
  logic        muxOpcode, muxSelectPC, muxSelectAddress, muxSelectALUtoAC;
  logic        muxSelectMEM_or_R_toAC, halted;
  logic [2:0]  state_dbg;
  logic [13:0] outs;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  control_unit #(.OPW(8), .HALT_OP(8'hFF)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ACisZero(ACisZero),
    .writeEnableAC(writeEnableAC), .writeEnableR(writeEnableR),
    .writeEnableMem(writeEnableMem), .PCEnable(PCEnable),
    .instructionRegisterEnable(instructionRegisterEnable),
    .MSBaddressEnable(MSBaddressEnable), .LSBaddressEnable(LSBaddressEnable),
    .zeroEnable(zeroEnable), .muxOpcode(muxOpcode), .muxSelectPC(muxSelectPC),
    .muxSelectAddress(muxSelectAddress), .muxSelectALUtoAC(muxSelectALUtoAC),
    .muxSelectMEM_or_R_toAC(muxSelectMEM_or_R_toAC), .halted(halted),
    .state_dbg(state_dbg)
  );

  assign outs = {writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
                 instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable,
                 zeroEnable, muxOpcode, muxSelectPC, muxSelectAddress,
                 muxSelectALUtoAC, muxSelectMEM_or_R_toAC, halted};

  // ---------------- datapath + memory ----------------
  bit   [7:0]  mem [65536];
  logic [15:0] pc;
  logic [7:0]  ir, msb, lsb, ac, r;
  logic        z;
  int          pc_pulses, mem_writes;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic [15:0] mem_addr;
  logic [7:0]  mem_byte, ac_in;

  function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a + 8'd1;
      3'd3:    return 8'd0;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign mem_addr = muxSelectAddress ? {msb, lsb} : pc;
  assign mem_byte = mem[mem_addr];
  assign opcode   = muxOpcode ? mem_byte : ir;
  assign ACisZero = z;
  assign ac_in    = muxSelectALUtoAC ? (muxSelectMEM_or_R_toAC ? mem_byte : r)
                                     : alu(ir[2:0], ac, r);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0; ir <= '0; msb <= '0; lsb <= '0; ac <= '0; r <= '0; z <= 1'b0;
      pc_pulses <= 0; mem_writes <= 0;
    end else begin
      if (instructionRegisterEnable) ir <= mem_byte;
      if (PCEnable) begin
        pc        <= muxSelectPC ? {msb, lsb} : pc + 16'd1;
        pc_pulses <= pc_pulses + 1;
      end
      if (MSBaddressEnable) msb <= mem_byte;
      if (LSBaddressEnable) lsb <= mem_byte;
      if (writeEnableAC)    ac  <= ac_in;
      if (zeroEnable)       z   <= (ac_in == 8'd0);
      if (writeEnableR)     r   <= ac;
      if (writeEnableMem)   mem_writes <= mem_writes + 1;
    end
  end

  always @(posedge clk) begin
    if (ld_en)               mem[ld_addr]  <= ld_data;
    else if (writeEnableMem) mem[mem_addr] <= ac;
  end

  // ---------------- ISA-level reference ----------------
  bit   [7:0]  m_mem [65536];
  logic [15:0] m_pc;
  logic [7:0]  m_ac, m_r;
  logic        m_z, m_halt;

  task automatic ref_step(output int cyc, output int pulses, output int writes,
                          output logic [15:0] g);
    logic [7:0] op;
    op = m_mem[m_pc]; m_pc = m_pc + 16'd1;
    cyc = 2; pulses = 1; writes = 0; g = '0;
    if (op == 8'hFF) begin
      m_halt = 1'b1;
    end else if (op inside {8'h01, 8'h02, 8'h05, 8'h06, 8'h07}) begin
      g = {m_mem[m_pc], m_mem[m_pc + 16'd1]};
      m_pc = m_pc + 16'd2; cyc = 5; pulses = 3;
      if (op == 8'h01) begin
        m_ac = m_mem[g]; m_z = (m_ac == 8'd0);
      end else if (op == 8'h02) begin
        m_mem[g] = m_ac; writes = 1;
      end else if (op == 8'h05 || (op == 8'h06 && m_z) || (op == 8'h07 && !m_z)) begin
        m_pc = g; pulses = 4;
      end
    end else if (op == 8'h03) begin
      m_r = m_ac;
    end else if (op == 8'h04) begin
      m_ac = m_r; m_z = (m_ac == 8'd0);
    end else if (op >= 8'h08 && op <= 8'h0F) begin
      m_ac = alu(op[2:0], m_ac, m_r); m_z = (m_ac == 8'd0);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d; m_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic put_prog(input logic [15:0] a, input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) put(a + 16'(i), b[8*(n-1-i) +: 8]);
  endtask

  task automatic hold_reset();
    reset = 1'b0; #1;
  endtask

  task automatic start_prog();
    m_pc = '0; m_ac = '0; m_r = '0; m_z = 1'b0; m_halt = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", 32'(state_dbg), 32'(FETCH));
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    reset = 1'b1;
  endtask

  task automatic run_instr();
    int cyc, e_cyc, e_pul, e_wr, p0, w0;
    logic [15:0] g, pc_h;
    p0 = pc_pulses; w0 = mem_writes; cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (state_dbg != 3'(FETCH) && state_dbg != 3'(HALT) && cyc < 8);
    ref_step(e_cyc, e_pul, e_wr, g);
    chk("cycles", 32'(cyc), 32'(e_cyc));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ac", 32'(ac), 32'(m_ac));
    chk("r", 32'(r), 32'(m_r));
    chk("zero", 32'(z), 32'(m_z));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("pc_loads", 32'(pc_pulses - p0), 32'(e_pul));
    chk("mem_writes", 32'(mem_writes - w0), 32'(e_wr));
    if (e_wr != 0) chk("mem_data", 32'(mem[g]), 32'(m_mem[g]));
    if (m_halt) begin
      pc_h = pc;
      repeat (3) begin @(posedge clk); #1; end
      chk("halt_sticky", 32'(outs), 32'd1);
      chk("halt_state", 32'(state_dbg), 32'(HALT));
      chk("halt_pc", 32'(pc), 32'(pc_h));
    end
  endtask

  task automatic gen_prog();
    int a, k;
    logic [7:0] op;
    a = 0;
    while (a < 248) begin
      k = int'($urandom_range(0, 17));
      if (k < 16)       op = 8'(k);
      else if (k == 16) op = 8'h3C;
      else              op = 8'($urandom_range(16, 254));
      put(16'(a), op); a++;
      if (op == 8'h01 || op == 8'h02) begin
        put(16'(a), 8'h40); put(16'(a + 1), 8'($urandom_range(0, 15))); a += 2;
      end else if (op inside {8'h05, 8'h06, 8'h07}) begin
        put(16'(a), 8'h00); put(16'(a + 1), 8'($urandom_range(0, 240))); a += 2;
      end
    end
    while (a < 256) begin put(16'(a), 8'h00); a++; end
    for (int i = 0; i < 16; i++) put(16'h4000 + 16'(i), 8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    hold_reset();

    // LDAC then HALT
    put_prog(16'h0000, 128'({8'h01, 8'h00, 8'h10, 8'hFF}), 4);
    put(16'h0010, 8'h5A);
    start_prog();
    run_instr();
    chk("t1_ac", 32'(ac), 32'h5A);
    chk("t1_zero", 32'(z), 32'd0);
    run_instr();
    chk("t1_pc", 32'(pc), 32'h0004);

    // LDAC, MVAC, INAC, ADD, STAC
    hold_reset();
    put_prog(16'h0000, 128'({8'h01, 8'h00, 8'h10, 8'h03, 8'h0A, 8'h08,
                             8'h02, 8'h00, 8'h20, 8'hFF}), 10);
    put(16'h0010, 8'h03); put(16'h0020, 8'h00);
    start_prog();
    repeat (6) run_instr();
    chk("t2_mem", 32'(mem[16'h0020]), 32'h07);
    chk("t2_r", 32'(r), 32'h03);

    // CLAC, JMPZ taken, INAC, JMPZ not taken
    hold_reset();
    put_prog(16'h0000, 128'({8'h0B, 8'h06, 8'h00, 8'h40}), 4);
    put_prog(16'h0040, 128'({8'h0A, 8'h06, 8'h00, 8'h50, 8'hFF}), 5);
    start_prog();
    run_instr(); run_instr();
    chk("t3_jmpz_taken", 32'(pc), 32'h0040);
    run_instr(); run_instr();
    chk("t3_jmpz_fall", 32'(pc), 32'h0044);
    run_instr();

    // JPNZ not taken with AC=0, JUMP 1234
    hold_reset();
    put_prog(16'h0000, 128'({8'h0B, 8'h07, 8'h00, 8'h30, 8'h05, 8'h12, 8'h34}), 7);
    put(16'h1234, 8'hFF);
    start_prog();
    run_instr(); run_instr();
    chk("t4_jpnz_fall", 32'(pc), 32'h0004);
    run_instr();
    chk("t4_jump", 32'(pc), 32'h1234);
    run_instr();

    // Reset asserted in ADDR_LO of a STAC
    hold_reset();
    put_prog(16'h0000, 128'({8'h01, 8'h00, 8'h10, 8'h02, 8'h00, 8'h20}), 6);
    put(16'h0010, 8'h5A); put(16'h0020, 8'h00);
    start_prog();
    run_instr();
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_in_addr_lo", 32'(state_dbg), 32'(ADDR_LO));
    reset = 1'b0; #1;
    chk("t5_state", 32'(state_dbg), 32'(FETCH));
    chk("t5_outs", 32'(outs), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    chk("t5_no_write", 32'(mem[16'h0020]), 32'h00);
    start_prog();
    run_instr();
    chk("t5_refetch_pc", 32'(pc), 32'h0003);

    // Unmapped opcode runs as NOP
    hold_reset();
    put_prog(16'h0000, 128'({8'h3C, 8'hA7, 8'hFF}), 3);
    start_prog();
    repeat (3) run_instr();

    // Random programs
    for (int p = 0; p < 5; p++) begin
      hold_reset();
      gen_prog();
      start_prog();
      for (int i = 0; i < 150 && !m_halt; i++) run_instr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
